// File: rtl/keypad_pkg.sv
// Shared key codes, scanner FSM states and lookup helpers for the keypad
// scanner and the arithmetic block that consumes its key codes.
package keypad_pkg;

    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_EQUAL = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_STAR  = 4'd13;
    localparam logic [3:0] KEY_HASH  = 4'd14;
    localparam logic [3:0] KEY_D     = 4'd15;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = KEY_ADD;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = KEY_EQUAL;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_CLEAR;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            4'd15:   code = KEY_D;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Column index of an active-low one-cold column drive.
    function automatic logic [1:0] col_index(input logic [3:0] col_drive);
        logic [1:0] idx;
        case (col_drive)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        casez (rows)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a configurable
// reset value so idle pulled-up lines read as inactive out of reset.
module sync_2ff #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotates the column drive, debounces press
// and release on dwell-end ticks, and strobes one key code per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_pulse,
    output logic       key_held
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       rows_s;
    logic             tick_s;
    logic [1:0]       cur_col_s;
    logic [3:0]       col_rot_s;
    logic [CNT_W-1:0] cnt_inc_s;

    kp_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       code_q, code_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;

    sync_2ff #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_row_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (row_in),
        .q_out(rows_s)
    );

    assign tick_s    = (div_q == DIV_LAST);
    assign cur_col_s = col_index(col_q);
    assign col_rot_s = {col_q[2:0], col_q[3]};
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Next-state logic; everything except the divider moves only on a tick.
    always_comb begin
        state_d = state_q;
        div_d   = tick_s ? {DIV_W{1'b0}} : div_q + DIV_ONE;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        held_d  = held_q;
        if (tick_s) begin
            case (state_q)
                SCAN: begin
                    if (rows_s == 4'hF) begin
                        col_d = col_rot_s;
                    end else if (CNT_DONE == CNT_ONE) begin
                        row_d   = lowest_low_row(rows_s);
                        code_d  = key_map(lowest_low_row(rows_s), cur_col_s);
                        pulse_d = 1'b1;
                        held_d  = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = HELD;
                    end else begin
                        row_d   = lowest_low_row(rows_s);
                        cnt_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s[row_q]) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = SCAN;
                    end else if (cnt_inc_s == CNT_DONE) begin
                        code_d  = key_map(row_q, cur_col_s);
                        pulse_d = 1'b1;
                        held_d  = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                HELD: begin
                    // Release is judged on the accepted row only, so a second key
                    // in the same column is picked up as a fresh press afterwards.
                    if (!rows_s[row_q]) begin
                        cnt_d = {CNT_W{1'b0}};
                    end else if (cnt_inc_s == CNT_DONE) begin
                        held_d  = 1'b0;
                        cnt_d   = {CNT_W{1'b0}};
                        col_d   = col_rot_s;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    cnt_d   = {CNT_W{1'b0}};
                    held_d  = 1'b0;
                    state_d = SCAN;
                end
            endcase
        end else begin
            pulse_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            div_q   <= {DIV_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            col_q   <= 4'b1110;
            row_q   <= 2'd0;
            code_q  <= 4'd0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign col_out   = col_q;
    assign key_code  = code_q;
    assign key_pulse = pulse_q;
    assign key_held  = held_q;

endmodule
